// File: rtl/servo_pkg.sv
// servo_pkg: shared definitions for the multi-channel servo PWM block.
//   - byte offsets of the AXI4-Lite register map
//   - reset defaults for PERIOD and PULSE registers
//   - AXI slave FSM state types
//   - clamp_us(): range clamp for pulse widths
//   - merge16(): byte-lane merge of a 16-bit register under WSTRB
package servo_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_PERIOD = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_PULSE0 = 8'h10;

  localparam logic [15:0] PERIOD_RST = 16'd20000;
  localparam logic [15:0] PULSE_RST  = 16'd1500;

  typedef enum logic {WR_IDLE = 1'b0, WR_RESP = 1'b1} wr_state_e;
  typedef enum logic {RD_IDLE = 1'b0, RD_DATA = 1'b1} rd_state_e;

  function automatic logic [15:0] clamp_us(input logic [15:0] val,
                                           input logic [15:0] min_us,
                                           input logic [15:0] max_us);
    if (val < min_us) return min_us;
    if (val > max_us) return max_us;
    return val;
  endfunction

  function automatic logic [15:0] merge16(input logic [15:0] old_v,
                                          input logic [15:0] new_v,
                                          input logic [1:0]  strb);
    return {strb[1] ? new_v[15:8] : old_v[15:8],
            strb[0] ? new_v[7:0]  : old_v[7:0]};
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// servo_pwm_channel: one PWM output. High while the frame counter is below
// the shadowed pulse width and the channel is enabled; output is registered.
//   clk, rst  : clock, asynchronous active-high reset
//   en        : global EN & shadowed channel enable
//   cnt       : shared frame counter (µs ticks)
//   pulse_sh  : shadowed pulse width, µs
//   pwm       : registered PWM output
module servo_pwm_channel (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] cnt,
  input  logic [15:0] pulse_sh,
  output logic        pwm
);

  logic pwm_q, pwm_d;

  always_comb begin
    pwm_d = en && (cnt < pulse_sh);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_q <= 1'b0;
    else     pwm_q <= pwm_d;
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/servo_pwm_axi_multi.sv
// servo_pwm_axi_multi: NUM_CH servo PWM channels sharing one frame timebase,
// configured through an AXI4-Lite slave register file.
//   s00_axi_aclk / s00_axi_areset : clock, asynchronous active-high reset
//   s00_axi_aw*/w*/b*/ar*/r*      : AXI4-Lite slave
//   servo_pwm[NUM_CH-1:0]         : PWM outputs, bit k = channel k
//   frame_irq                     : one-cycle pulse when a new frame starts
// Handshake: write accepted when AWVALID & WVALID in WR_IDLE (AWREADY/WREADY
// high that cycle only), BVALID held in WR_RESP until BREADY; read accepted
// when ARVALID in RD_IDLE, RVALID/RDATA held in RD_DATA until RREADY.
module servo_pwm_axi_multi
  import servo_pkg::*;
#(
  parameter int NUM_CH             = 4,
  parameter int PRESCALE_DIV       = 100,
  parameter int MIN_US             = 500,
  parameter int MAX_US             = 2500,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [NUM_CH-1:0]               servo_pwm,
  output logic                            frame_irq
);

  localparam int WW = C_S_AXI_ADDR_WIDTH - 2;
  localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [15:0]   MIN_V      = 16'(MIN_US);
  localparam logic [15:0]   MAX_V      = 16'(MAX_US);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE_DIV - 1);

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  logic      wr_acc, rd_acc;
  logic [WW-1:0] wword, rword;

  logic                   en_q, en_d;
  logic [NUM_CH-1:0]      chen_q, chen_d;
  logic [15:0]            period_q, period_d;
  logic [NUM_CH-1:0][15:0] pulse_q, pulse_d;
  logic [15:0]            period_m, pulse_m, pulse_old;
  logic [31:0]            rdata_q, rdata_d, rd_word;

  logic [PW-1:0]          presc_q, presc_d;
  logic [15:0]            cnt_q, cnt_d, fcnt_q, fcnt_d;
  logic                   irq_q, irq_d;
  logic [15:0]            per_sh_q, per_sh_d;
  logic [NUM_CH-1:0][15:0] pulse_sh_q, pulse_sh_d;
  logic [NUM_CH-1:0]      chen_sh_q, chen_sh_d;
  logic                   tick, wrap, load_sh;

  // Address bits below the word boundary and the upper data/strobe lanes
  // carry no register content.
  logic unused_bits;
  assign unused_bits = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0],
                         s00_axi_wdata[C_S_AXI_DATA_WIDTH-1:16],
                         s00_axi_wstrb[C_S_AXI_DATA_WIDTH/8-1:2]};

  assign wword = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign rword = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];

  // Write channel FSM
  always_comb begin
    wr_state_d = wr_state_q;
    wr_acc     = 1'b0;
    unique case (wr_state_q)
      WR_IDLE: if (s00_axi_awvalid && s00_axi_wvalid) begin
        wr_acc     = 1'b1;
        wr_state_d = WR_RESP;
      end
      WR_RESP: if (s00_axi_bready) wr_state_d = WR_IDLE;
    endcase
  end

  // Read channel FSM
  always_comb begin
    rd_state_d = rd_state_q;
    rd_acc     = 1'b0;
    unique case (rd_state_q)
      RD_IDLE: if (s00_axi_arvalid) begin
        rd_acc     = 1'b1;
        rd_state_d = RD_DATA;
      end
      RD_DATA: if (s00_axi_rready) rd_state_d = RD_IDLE;
    endcase
  end

  assign s00_axi_awready = wr_acc;
  assign s00_axi_wready  = wr_acc;
  assign s00_axi_bvalid  = (wr_state_q == WR_RESP);
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = rd_acc;
  assign s00_axi_rvalid  = (rd_state_q == RD_DATA);
  assign s00_axi_rresp   = 2'b00;
  assign s00_axi_rdata   = rdata_q;

  // Register file writes: byte-lane merge first, then clamp the merged value
  always_comb begin
    en_d      = en_q;
    chen_d    = chen_q;
    period_d  = period_q;
    pulse_d   = pulse_q;
    pulse_old = PULSE_RST;
    for (int k = 0; k < NUM_CH; k++) begin
      if (wword == WW'((OFF_PULSE0 >> 2) + 8'(k))) pulse_old = pulse_q[k];
    end
    period_m = merge16(period_q, s00_axi_wdata[15:0], s00_axi_wstrb[1:0]);
    pulse_m  = merge16(pulse_old, s00_axi_wdata[15:0], s00_axi_wstrb[1:0]);
    if (wr_acc) begin
      if (wword == WW'(OFF_CTRL >> 2)) begin
        if (s00_axi_wstrb[0]) en_d   = s00_axi_wdata[0];
        if (s00_axi_wstrb[1]) chen_d = s00_axi_wdata[8 +: NUM_CH];
      end
      if (wword == WW'(OFF_PERIOD >> 2)) begin
        period_d = (period_m > MAX_V) ? period_m : MAX_V + 16'd1;
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (wword == WW'((OFF_PULSE0 >> 2) + 8'(k))) begin
          pulse_d[k] = clamp_us(pulse_m, MIN_V, MAX_V);
        end
      end
    end
  end

  // Read mux samples the current (pre-write) register values
  always_comb begin
    rd_word = '0;
    if (rword == WW'(OFF_CTRL >> 2))   rd_word = 32'({chen_q, 7'b0, en_q});
    if (rword == WW'(OFF_PERIOD >> 2)) rd_word = 32'(period_q);
    if (rword == WW'(OFF_STATUS >> 2)) rd_word = 32'({en_q, fcnt_q});
    for (int k = 0; k < NUM_CH; k++) begin
      if (rword == WW'((OFF_PULSE0 >> 2) + 8'(k))) rd_word = 32'(pulse_q[k]);
    end
    rdata_d = rd_acc ? rd_word : rdata_q;
  end

  // Timebase and shadow load. Shadows take the *_d values so a register
  // write landing on the wrap edge (or the enabling write) is seen at once.
  always_comb begin
    tick    = en_q && (presc_q == PRESC_LAST);
    wrap    = tick && (cnt_q == per_sh_q - 16'd1);
    load_sh = wrap || (en_d && !en_q);
    presc_d = '0;
    cnt_d   = '0;
    if (en_q) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) cnt_d = wrap ? 16'd0 : cnt_q + 16'd1;
      else      cnt_d = cnt_q;
    end
    fcnt_d     = wrap ? fcnt_q + 16'd1 : fcnt_q;
    irq_d      = wrap;
    per_sh_d   = load_sh ? period_d : per_sh_q;
    pulse_sh_d = load_sh ? pulse_d  : pulse_sh_q;
    chen_sh_d  = load_sh ? chen_d   : chen_sh_q;
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      en_q       <= 1'b0;
      chen_q     <= '0;
      period_q   <= PERIOD_RST;
      pulse_q    <= {NUM_CH{PULSE_RST}};
      rdata_q    <= '0;
      presc_q    <= '0;
      cnt_q      <= '0;
      fcnt_q     <= '0;
      irq_q      <= 1'b0;
      per_sh_q   <= PERIOD_RST;
      pulse_sh_q <= {NUM_CH{PULSE_RST}};
      chen_sh_q  <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      en_q       <= en_d;
      chen_q     <= chen_d;
      period_q   <= period_d;
      pulse_q    <= pulse_d;
      rdata_q    <= rdata_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      fcnt_q     <= fcnt_d;
      irq_q      <= irq_d;
      per_sh_q   <= per_sh_d;
      pulse_sh_q <= pulse_sh_d;
      chen_sh_q  <= chen_sh_d;
    end
  end

  assign frame_irq = irq_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    servo_pwm_channel u_ch (
      .clk      (s00_axi_aclk),
      .rst      (s00_axi_areset),
      .en       (en_q & chen_sh_q[k]),
      .cnt      (cnt_q),
      .pulse_sh (pulse_sh_q[k]),
      .pwm      (servo_pwm[k])
    );
  end

endmodule

// File: tb/tb_servo_pwm_axi_multi.sv
// Directed bench for servo_pwm_axi_multi with PRESCALE_DIV=2, so one µs is
// two clock cycles and a 2501 µs frame is 5002 cycles.
module tb_servo_pwm_axi_multi;

  localparam int NCH = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [5:0]     awaddr = '0, araddr = '0;
  logic           awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic           bready = 1'b1, rready = 1'b1;
  logic [31:0]    wdata = '0;
  logic [3:0]     wstrb = '0;
  logic           awready, wready, bvalid, arready, rvalid, frame_irq;
  logic [1:0]     bresp, rresp;
  logic [31:0]    rdata;
  logic [NCH-1:0] servo_pwm;

  servo_pwm_axi_multi #(
    .NUM_CH(NCH), .PRESCALE_DIV(2), .MIN_US(500), .MAX_US(2500),
    .C_S_AXI_ADDR_WIDTH(6), .C_S_AXI_DATA_WIDTH(32)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid),
    .s00_axi_wready(wready), .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid),
    .s00_axi_bready(bready), .s00_axi_araddr(araddr), .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready), .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
    .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .servo_pwm(servo_pwm), .frame_irq(frame_irq)
  );

  int checks = 0;
  int errors = 0;
  int wr_done_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    while (!(awready && wready) && n < 16) begin
      @(negedge clk); #1; n++;
    end
    check("wr_ready", 32'({awready, wready}), 32'h3);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    wr_done_cyc = cyc;
    check("bvalid", 32'(bvalid), 32'h1);
    check("bresp", 32'(bresp), 32'h0);
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    #1;
    while (!arready && n < 16) begin
      @(negedge clk); #1; n++;
    end
    check("arready", 32'(arready), 32'h1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("rvalid", 32'(rvalid), 32'h1);
    check("rresp", 32'(rresp), 32'h0);
    d = rdata;
  endtask

  function automatic logic sig(input int sel);
    if (sel < NCH) return servo_pwm[sel[1:0]];
    return frame_irq;
  endfunction

  // Advance negedge by negedge until the selected signal equals val
  // (sel 0..3 = servo_pwm bit, 4 = frame_irq); returns the cycle seen.
  task automatic wait_until(input int sel, input logic val, input int bound, output int at);
    int n;
    n = 0;
    @(negedge clk);
    while (sig(sel) !== val && n < bound) begin
      @(negedge clk); n++;
    end
    at = cyc;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  logic [31:0] d;
  int w, f, f2, f3, at, acc;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pwm", 32'(servo_pwm), 32'h0);
    check("rst_irq", 32'(frame_irq), 32'h0);
    check("rst_bvalid", 32'(bvalid), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    axi_read(6'h00, d); check("ctrl_rst", d, 32'd0);
    axi_read(6'h04, d); check("period_rst", d, 32'd20000);
    axi_read(6'h10, d); check("pulse0_rst", d, 32'd1500);
    axi_read(6'h1C, d); check("pulse3_rst", d, 32'd1500);
    axi_read(6'h08, d); check("status_rst", d, 32'd0);

    // 1 ms idle (1000 ticks of 2 cycles): no irq, no pulse
    acc = 0;
    repeat (2000) begin
      @(negedge clk);
      acc += int'(frame_irq) + int'(servo_pwm != 0);
    end
    check("idle_quiet", 32'(acc), 32'd0);

    // Clamping
    axi_write(6'h14, 32'd100, 4'hF);  axi_read(6'h14, d); check("clamp_low", d, 32'd500);
    axi_write(6'h1C, 32'd3000, 4'hF); axi_read(6'h1C, d); check("clamp_high", d, 32'd2500);
    axi_write(6'h04, 32'd50, 4'hF);   axi_read(6'h04, d); check("period_min", d, 32'd2501);

    // Byte strobes: only the low byte of 0x05DC replaced by 0x34
    axi_write(6'h18, 32'hFFFF_1234, 4'h1); axi_read(6'h18, d); check("wstrb", d, 32'h0534);

    // Unmapped and read-only offsets
    axi_write(6'h3C, 32'hDEAD_BEEF, 4'hF); axi_read(6'h3C, d); check("unmapped_rd", d, 32'd0);
    axi_read(6'h0C, d); check("hole_rd", d, 32'd0);
    axi_write(6'h08, 32'hFFFF_FFFF, 4'hF); axi_read(6'h08, d); check("status_ro", d, 32'd0);

    // Basic PWM: ch0 at 1000 µs, frame 2501 µs
    axi_write(6'h10, 32'd1000, 4'hF); axi_read(6'h10, d); check("pulse0_wr", d, 32'd1000);
    axi_write(6'h00, 32'h101, 4'hF);
    w = wr_done_cyc;
    wait_until(0, 1'b1, 12000, at); check("pwm0_rise", 32'(at), 32'(w + 1));
    check("ch_off", 32'(servo_pwm[3:1]), 32'd0);
    wait_until(0, 1'b0, 12000, at); check("pwm0_fall", 32'(at), 32'(w + 2001));
    wait_until(4, 1'b1, 12000, at); check("irq1", 32'(at), 32'(w + 5002));
    @(negedge clk); check("irq_width", 32'(frame_irq), 32'd0);
    wait_until(4, 1'b1, 12000, f); check("irq2", 32'(f), 32'(w + 10004));

    // Glitch-free update at cnt=500: current pulse stays 1000 µs
    wait_to(f + 999);
    axi_write(6'h10, 32'd2000, 4'hF);
    wait_until(0, 1'b0, 12000, at); check("old_width", 32'(at), 32'(f + 2001));
    axi_read(6'h10, d); check("pulse0_new", d, 32'd2000);
    wait_until(4, 1'b1, 12000, f2); check("irq3", 32'(f2), 32'(f + 5002));
    wait_to(f2 + 2001); check("new_width_mid", 32'(servo_pwm[0]), 32'd1);
    wait_until(0, 1'b0, 12000, at); check("new_width", 32'(at), 32'(f2 + 4001));
    wait_until(4, 1'b1, 12000, f3); check("irq4", 32'(f3), 32'(f2 + 5002));

    // Disable mid-pulse at cnt=300
    wait_to(f3 + 599);
    axi_write(6'h00, 32'h0, 4'hF);
    @(negedge clk); check("dis_pwm_p1", 32'(servo_pwm[0]), 32'd1);
    @(negedge clk); check("dis_pwm_p2", 32'(servo_pwm), 32'd0);
    axi_read(6'h08, d); check("status_dis", d, 32'h0000_0004);
    acc = 0;
    repeat (200) begin
      @(negedge clk);
      acc += int'(frame_irq) + int'(servo_pwm != 0);
    end
    check("dis_quiet", 32'(acc), 32'd0);

    // Re-enable ch0 (2000 µs) and ch1 (500 µs): full pulses from frame start
    axi_write(6'h00, 32'h301, 4'hF);
    w = wr_done_cyc;
    wait_until(0, 1'b1, 12000, at); check("reen_rise", 32'(at), 32'(w + 1));
    check("reen_both", 32'(servo_pwm), 32'h3);
    wait_until(1, 1'b0, 12000, at); check("ch1_fall", 32'(at), 32'(w + 1001));
    check("ch0_still", 32'(servo_pwm), 32'h1);
    axi_read(6'h08, d); check("status_en", d, 32'h0001_0004);

    // Asynchronous reset mid-pulse
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_pwm", 32'(servo_pwm), 32'h0);
    check("arst_irq", 32'(frame_irq), 32'h0);
    check("arst_bvalid", 32'(bvalid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    axi_read(6'h00, d); check("arst_ctrl", d, 32'd0);
    axi_read(6'h04, d); check("arst_period", d, 32'd20000);
    axi_read(6'h10, d); check("arst_pulse0", d, 32'd1500);
    axi_read(6'h14, d); check("arst_pulse1", d, 32'd1500);
    axi_read(6'h08, d); check("arst_status", d, 32'd0);
    acc = 0;
    repeat (50) begin
      @(negedge clk);
      acc += int'(servo_pwm != 0);
    end
    check("arst_quiet", 32'(acc), 32'd0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
